// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel fetch path: fetch FSM states and default widths.
// FIFO writers place the start-of-frame tag at bit SOF_BIT, just above the pixel data.
package vga_pkg;

    localparam int DATA_WIDTH_DEF = 24;
    localparam int FIFO_WIDTH_DEF = 11;
    localparam int CNT_WIDTH_DEF  = 16;
    localparam int SOF_BIT        = DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        ARM    = 2'd2,
        STREAM = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/vga_pixel_fetch_if.sv
// Timing stream in/out, FIFO head/pop and status bundle for vga_pixel_fetch.
// slave is the fetch block; master is whatever drives timing and owns the FIFO.
interface vga_pixel_fetch_if
    import vga_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) ();

    logic [FIFO_WIDTH-1:0] in_x;
    logic [FIFO_WIDTH-1:0] in_y;
    logic                  in_valid;
    logic                  in_de;
    logic                  in_hs;
    logic                  in_vs;
    logic [DATA_WIDTH-1:0] in_fifo_data;
    logic                  in_fifo_sof;
    logic                  in_fifo_empty;
    logic                  in_clr_status;

    logic                  out_fifo_rd;
    logic [DATA_WIDTH-1:0] out_rgb;
    logic [FIFO_WIDTH-1:0] out_x;
    logic [FIFO_WIDTH-1:0] out_y;
    logic                  out_valid;
    logic                  out_de;
    logic                  out_hs;
    logic                  out_vs;
    logic                  out_underflow;
    logic                  out_sync_err;
    logic [CNT_WIDTH-1:0]  out_underflow_cnt;
    logic [CNT_WIDTH-1:0]  out_frame_cnt;

    modport slave (
        input  in_x, in_y, in_valid, in_de, in_hs, in_vs,
        input  in_fifo_data, in_fifo_sof, in_fifo_empty, in_clr_status,
        output out_fifo_rd, out_rgb, out_x, out_y, out_valid, out_de, out_hs, out_vs,
        output out_underflow, out_sync_err, out_underflow_cnt, out_frame_cnt
    );

    modport master (
        output in_x, in_y, in_valid, in_de, in_hs, in_vs,
        output in_fifo_data, in_fifo_sof, in_fifo_empty, in_clr_status,
        input  out_fifo_rd, out_rgb, out_x, out_y, out_valid, out_de, out_hs, out_vs,
        input  out_underflow, out_sync_err, out_underflow_cnt, out_frame_cnt
    );

endinterface

// File: rtl/vga_pixel_fetch.sv
// Aligns FIFO pixels to the timing stream using the SOF tag; flags underflow/misalignment.
// Latency: 1 cycle on every output; out_fifo_rd is combinational from the FIFO head.
// No backpressure: timing is never stalled, an empty FIFO substitutes black pixels.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic             in_pclk,
    input  logic             in_rst,
    vga_pixel_fetch_if.slave bus
);

    fetch_state_t          state, state_nxt;
    logic                  first_pix, first_nxt;
    logic [DATA_WIDTH-1:0] rgb_q;
    logic [FIFO_WIDTH-1:0] x_q, y_q;
    logic                  valid_q, de_q, hs_q, vs_q;
    logic                  uf_flag, sync_flag;
    logic [CNT_WIDTH-1:0]  uf_cnt, frame_cnt;

    logic fs, stream_act, first_eff, head_match, slot;
    logic pop, seek_pop, uf_ev, sync_ev, frame_ev;

    assign fs         = bus.in_vs & ~vs_q;
    // A frame start in ARM is taken first, so a same-cycle slot is treated as streaming.
    assign stream_act = (state == STREAM) || ((state == ARM) && fs);
    assign first_eff  = fs | first_pix;
    assign head_match = (bus.in_fifo_sof == first_eff);
    assign slot       = stream_act & bus.in_valid;
    assign pop        = slot & ~bus.in_fifo_empty & head_match;
    assign uf_ev      = slot & bus.in_fifo_empty;
    assign sync_ev    = slot & ~bus.in_fifo_empty & ~head_match;
    assign frame_ev   = fs & ((state == ARM) || (state == STREAM));
    assign seek_pop   = (state == SEEK) & ~bus.in_fifo_empty & ~bus.in_fifo_sof;

    assign bus.out_fifo_rd = ~in_rst & (seek_pop | pop);

    always_comb begin
        state_nxt = state;
        first_nxt = first_pix;
        case (state)
            IDLE:    state_nxt = SEEK;
            SEEK:    if (~bus.in_fifo_empty & bus.in_fifo_sof) state_nxt = ARM;
            ARM:     if (fs) state_nxt = STREAM;
            default: state_nxt = state;
        endcase
        if (stream_act) begin
            first_nxt = first_eff & ~pop;
            // Early next-frame tag waits for its frame start; a missing tag rescans.
            if (sync_ev) state_nxt = bus.in_fifo_sof ? ARM : SEEK;
        end
    end

    always_ff @(posedge in_pclk) begin
        if (in_rst) begin
            state     <= IDLE;
            first_pix <= 1'b0;
            rgb_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            de_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            uf_flag   <= 1'b0;
            sync_flag <= 1'b0;
            uf_cnt    <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            first_pix <= first_nxt;
            rgb_q     <= pop ? bus.in_fifo_data : '0;
            x_q       <= bus.in_x;
            y_q       <= bus.in_y;
            valid_q   <= bus.in_valid;
            de_q      <= bus.in_de;
            hs_q      <= bus.in_hs;
            vs_q      <= bus.in_vs;
            uf_flag   <= (uf_flag & ~bus.in_clr_status) | uf_ev;
            sync_flag <= (sync_flag & ~bus.in_clr_status) | sync_ev;
            // Clear and event in the same cycle leave the counter at one.
            if (bus.in_clr_status)
                uf_cnt <= {{(CNT_WIDTH-1){1'b0}}, uf_ev};
            else if (uf_ev && (uf_cnt != {CNT_WIDTH{1'b1}}))
                uf_cnt <= uf_cnt + 1'b1;
            if (bus.in_clr_status)
                frame_cnt <= {{(CNT_WIDTH-1){1'b0}}, frame_ev};
            else if (frame_ev)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign bus.out_rgb           = rgb_q;
    assign bus.out_x             = x_q;
    assign bus.out_y             = y_q;
    assign bus.out_valid         = valid_q;
    assign bus.out_de            = de_q;
    assign bus.out_hs            = hs_q;
    assign bus.out_vs            = vs_q;
    assign bus.out_underflow     = uf_flag;
    assign bus.out_sync_err      = sync_flag;
    assign bus.out_underflow_cnt = uf_cnt;
    assign bus.out_frame_cnt     = frame_cnt;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench: 8x4 active frames, queue-backed FWFT FIFO, hand-computed expected pixels.
module tb_vga_pixel_fetch;
    import vga_pkg::*;

    logic in_pclk;
    logic in_rst;

    vga_pixel_fetch_if bus ();

    vga_pixel_fetch dut (
        .in_pclk (in_pclk),
        .in_rst  (in_rst),
        .bus     (bus)
    );

    initial in_pclk = 1'b0;
    always #5 in_pclk = ~in_pclk;

    logic [SOF_BIT:0]          fifo_q[$];
    logic [DATA_WIDTH_DEF-1:0] exp_pix[32];
    logic                      last_rd;
    int                        n_tests = 0;
    int                        n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic update_head();
        logic [SOF_BIT:0] w;
        bus.in_fifo_empty = (fifo_q.size() == 0);
        w = '0;
        if (fifo_q.size() != 0) w = fifo_q[0];
        bus.in_fifo_data = w[DATA_WIDTH_DEF-1:0];
        bus.in_fifo_sof  = w[SOF_BIT];
    endtask

    task automatic push(input logic sof, input logic [DATA_WIDTH_DEF-1:0] d);
        fifo_q.push_back({sof, d});
        update_head();
    endtask

    task automatic load_frame(input logic [DATA_WIDTH_DEF-1:0] base, input int n);
        for (int i = 0; i < n; i++) push(i == 0, base + DATA_WIDTH_DEF'(i));
    endtask

    task automatic set_exp(input logic [DATA_WIDTH_DEF-1:0] base, input int n);
        for (int k = 0; k < 32; k++) exp_pix[k] = (k < n) ? base + DATA_WIDTH_DEF'(k) : '0;
    endtask

    task automatic drive(input logic v, input logic de, input logic hs, input logic vs,
                         input int x, input int y);
        bus.in_valid = v;
        bus.in_de    = de;
        bus.in_hs    = hs;
        bus.in_vs    = vs;
        bus.in_x     = FIFO_WIDTH_DEF'(x);
        bus.in_y     = FIFO_WIDTH_DEF'(y);
    endtask

    // Inputs change at posedge+1; pop decision sampled before the edge, applied after it.
    task automatic tick();
        logic             rd_s;
        logic [SOF_BIT:0] w;
        #1;
        rd_s    = bus.out_fifo_rd;
        last_rd = rd_s;
        if (rd_s && bus.in_fifo_empty) chk("rd_when_empty", 32'(rd_s), 32'd0);
        @(posedge in_pclk);
        #1;
        if (rd_s && fifo_q.size() != 0) w = fifo_q.pop_front();
        update_head();
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        bus.in_clr_status = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        tick();
        tick();
        chk("rst_rd",       32'(last_rd), 32'd0);
        chk("rst_rgb",      32'(bus.out_rgb), 32'd0);
        chk("rst_vs",       32'(bus.out_vs), 32'd0);
        chk("rst_valid",    32'(bus.out_valid), 32'd0);
        chk("rst_uf",       32'(bus.out_underflow), 32'd0);
        chk("rst_sync",     32'(bus.out_sync_err), 32'd0);
        chk("rst_uf_cnt",   32'(bus.out_underflow_cnt), 32'd0);
        chk("rst_frame_cnt", 32'(bus.out_frame_cnt), 32'd0);
        in_rst = 1'b0;
    endtask

    // One frame: 2 cycles vsync, 2 back-porch cycles, 4 lines of 8 pixels + 3 blank.
    task automatic run_frame(input int rst_at, input int clr_at);
        int k;
        for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0); tick(); end
        for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b0, 1'b1, 1'b1, 0, 0); tick(); end
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                k = y * 8 + x;
                drive(1'b1, 1'b1, 1'b1, 1'b1, x, y);
                in_rst = (k == rst_at);
                bus.in_clr_status = (k == clr_at);
                tick();
                in_rst = 1'b0;
                bus.in_clr_status = 1'b0;
                if (k == rst_at) begin
                    chk("midrst_rd",    32'(last_rd), 32'd0);
                    chk("midrst_rgb",   32'(bus.out_rgb), 32'd0);
                    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
                    chk("midrst_x",     32'(bus.out_x), 32'd0);
                end else begin
                    chk($sformatf("pix%0d", k), 32'(bus.out_rgb), 32'(exp_pix[k]));
                end
                if (k == clr_at) begin
                    chk("clr_uf_flag",   32'(bus.out_underflow), 32'd1);
                    chk("clr_uf_cnt",    32'(bus.out_underflow_cnt), 32'd1);
                    chk("clr_frame_cnt", 32'(bus.out_frame_cnt), 32'd0);
                end
                if (k == 9 && rst_at < 0) begin
                    chk("out_x",     32'(bus.out_x), 32'd1);
                    chk("out_y",     32'(bus.out_y), 32'd1);
                    chk("out_valid", 32'(bus.out_valid), 32'd1);
                end
            end
            drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0); tick();
            drive(1'b0, 1'b0, 1'b1, 1'b1, 0, 0); tick(); tick();
        end
    endtask

    initial begin
        in_rst = 1'b1;
        bus.in_clr_status = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        update_head();

        // Two clean frames back to back
        fifo_q.delete();
        load_frame(24'h100000, 32);
        load_frame(24'h110000, 32);
        do_reset();
        idle(4);
        set_exp(24'h100000, 32); run_frame(-1, -1);
        set_exp(24'h110000, 32); run_frame(-1, -1);
        chk("t1_frame_cnt", 32'(bus.out_frame_cnt), 32'd2);
        chk("t1_uf",        32'(bus.out_underflow), 32'd0);
        chk("t1_sync",      32'(bus.out_sync_err), 32'd0);
        chk("t1_fifo_left", 32'(fifo_q.size()), 32'd0);

        // Junk words ahead of the first tagged frame
        fifo_q.delete();
        for (int i = 0; i < 5; i++) push(1'b0, 24'hBAD000 + 24'(i));
        load_frame(24'h200000, 32);
        do_reset();
        idle(8);
        chk("t2_seek_pops", 32'(fifo_q.size()), 32'd32);
        set_exp(24'h200000, 32); run_frame(-1, -1);
        chk("t2_sync",      32'(bus.out_sync_err), 32'd0);
        chk("t2_uf",        32'(bus.out_underflow), 32'd0);
        chk("t2_frame_cnt", 32'(bus.out_frame_cnt), 32'd1);

        // Short frame -> underflow, then clear coinciding with an underflow slot
        fifo_q.delete();
        load_frame(24'h300000, 20);
        do_reset();
        idle(4);
        set_exp(24'h300000, 20); run_frame(-1, -1);
        chk("t3_uf",     32'(bus.out_underflow), 32'd1);
        chk("t3_uf_cnt", 32'(bus.out_underflow_cnt), 32'd12);
        chk("t3_sync",   32'(bus.out_sync_err), 32'd0);
        set_exp(24'h0, 0); run_frame(-1, 0);
        chk("t6_uf_cnt_end", 32'(bus.out_underflow_cnt), 32'd32);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        bus.in_clr_status = 1'b1;
        tick();
        bus.in_clr_status = 1'b0;
        chk("t6_clr_uf",        32'(bus.out_underflow), 32'd0);
        chk("t6_clr_uf_cnt",    32'(bus.out_underflow_cnt), 32'd0);
        chk("t6_clr_frame_cnt", 32'(bus.out_frame_cnt), 32'd0);

        // Truncated frame: next frame's tag seen early
        fifo_q.delete();
        load_frame(24'h400000, 30);
        load_frame(24'h410000, 32);
        do_reset();
        idle(4);
        set_exp(24'h400000, 30); run_frame(-1, -1);
        chk("t4_sync",      32'(bus.out_sync_err), 32'd1);
        chk("t4_fifo_left", 32'(fifo_q.size()), 32'd32);
        set_exp(24'h410000, 32); run_frame(-1, -1);
        chk("t4_frame_cnt", 32'(bus.out_frame_cnt), 32'd2);
        chk("t4_uf",        32'(bus.out_underflow), 32'd0);
        chk("t4_sync_held", 32'(bus.out_sync_err), 32'd1);

        // Reset mid-line, recover on the next tagged frame
        fifo_q.delete();
        load_frame(24'h500000, 32);
        load_frame(24'h510000, 32);
        do_reset();
        idle(4);
        set_exp(24'h500000, 10); run_frame(10, -1);
        set_exp(24'h510000, 32); run_frame(-1, -1);
        chk("t5_frame_cnt", 32'(bus.out_frame_cnt), 32'd1);
        chk("t5_sync",      32'(bus.out_sync_err), 32'd0);
        chk("t5_uf",        32'(bus.out_underflow), 32'd0);
        chk("t5_fifo_left", 32'(fifo_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
